// File: rtl/d_mem_ctrl_pkg.sv
// Shared data-memory types: LSQ op encoding, controller FSM state and latched request.
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 10
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

package d_mem_ctrl_pkg;

  localparam int unsigned AddrW = `D_MEMORY_ADDR_WIDTH;
  localparam int unsigned DataW = `REG_VAL_WIDTH;

  typedef enum logic [1:0] {
    no_mem_op = 2'd0,
    mem_read  = 2'd1,
    mem_write = 2'd2
  } memory_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } d_mem_ctrl_state_t;

  typedef struct packed {
    memory_op_t       op;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/d_mem_ctrl_if.sv
// LSQ request/response and data-RAM signals of the data-memory controller.
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 10
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

interface d_mem_ctrl_if;
  import d_mem_ctrl_pkg::*;

  logic                           lsq_req_valid;
  memory_op_t                     lsq_req_op;
  logic [`D_MEMORY_ADDR_WIDTH-1:0] lsq_req_address;
  logic [`REG_VAL_WIDTH-1:0]       lsq_req_data;
  logic                           mem_ctrl_ready;
  logic                           mem_ctrl_done;
  logic [`REG_VAL_WIDTH-1:0]       mem_ctrl_data;
  logic                           dmem_en;
  logic                           dmem_we;
  logic [`D_MEMORY_ADDR_WIDTH-1:0] dmem_addr;
  logic [`REG_VAL_WIDTH-1:0]       dmem_wdata;
  logic [`REG_VAL_WIDTH-1:0]       dmem_rdata;

  // LSQ side
  modport master (
    output lsq_req_valid, lsq_req_op, lsq_req_address, lsq_req_data,
    input  mem_ctrl_ready, mem_ctrl_done, mem_ctrl_data
  );

  // Controller side
  modport slave (
    input  lsq_req_valid, lsq_req_op, lsq_req_address, lsq_req_data, dmem_rdata,
    output mem_ctrl_ready, mem_ctrl_done, mem_ctrl_data,
    output dmem_en, dmem_we, dmem_addr, dmem_wdata
  );

  // Data RAM side
  modport ram (
    input  dmem_en, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata
  );

endinterface

// File: rtl/d_mem_ctrl.sv
// Data-memory controller: one in-order LSQ load/store at a time over a fixed-latency RAM.
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 10
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module d_mem_ctrl import d_mem_ctrl_pkg::*; #(
  parameter int unsigned MEM_LATENCY = 2,
  localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1)
) (
  input logic         clk,
  input logic         reset,
  d_mem_ctrl_if.slave bus
);

  d_mem_ctrl_state_t  state_q, state_d;
  mem_req_t           req_q, req_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DataW-1:0]   rdata_q, rdata_d;

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: accept in IDLE, one ISSUE cycle, MEM_LATENCY WAIT cycles, one RESP cycle
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.lsq_req_valid && (bus.lsq_req_op != no_mem_op)) begin
          req_d.op   = bus.lsq_req_op;
          req_d.addr = bus.lsq_req_address;
          req_d.data = bus.lsq_req_data;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (req_q.op == mem_read) begin
            rdata_d = bus.dmem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registers only; RAM bus and response data are zero outside their cycle
  always_comb begin
    bus.mem_ctrl_ready = (state_q == IDLE);
    bus.mem_ctrl_done  = 1'b0;
    bus.mem_ctrl_data  = '0;
    bus.dmem_en        = 1'b0;
    bus.dmem_we        = 1'b0;
    bus.dmem_addr      = '0;
    bus.dmem_wdata     = '0;
    unique case (state_q)
      ISSUE: begin
        bus.dmem_en    = 1'b1;
        bus.dmem_we    = (req_q.op == mem_write);
        bus.dmem_addr  = req_q.addr;
        bus.dmem_wdata = req_q.data;
      end
      RESP: begin
        bus.mem_ctrl_done = 1'b1;
        if (req_q.op == mem_read) begin
          bus.mem_ctrl_data = rdata_q;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_d_mem_ctrl.sv
// Bench for d_mem_ctrl: scoreboard of expected done cycle/data, plus latency variants 1 and 4.
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 10
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module tb_d_mem_ctrl;
  import d_mem_ctrl_pkg::*;

  localparam int unsigned Lat = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  d_mem_ctrl_if b2 ();
  d_mem_ctrl_if b1 ();
  d_mem_ctrl_if b4 ();

  d_mem_ctrl #(.MEM_LATENCY(2)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));
  d_mem_ctrl #(.MEM_LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
  d_mem_ctrl #(.MEM_LATENCY(4)) u_dut4 (.clk(clk), .reset(reset), .bus(b4));

  d_mem_model #(.MEM_LATENCY(2)) u_ram2 (.clk(clk), .bus(b2));
  d_mem_model #(.MEM_LATENCY(1)) u_ram1 (.clk(clk), .bus(b1));
  d_mem_model #(.MEM_LATENCY(4)) u_ram4 (.clk(clk), .bus(b4));

  typedef struct {
    int unsigned      cyc;
    logic [DataW-1:0] data;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int          en_cnt = 0;
  int          done_cnt = 0;

  // Cycle index and pulse counters for the latency-2 instance
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b2.dmem_en === 1'b1) en_cnt <= en_cnt + 1;
    if (b2.mem_ctrl_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Scoreboard: every done pulse must match the oldest expected cycle and data
  always @(negedge clk) begin
    if (b2.mem_ctrl_done === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected: done at cycle %0d, required no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cyc !== mon_e.cyc || b2.mem_ctrl_data !== mon_e.data) begin
          fails++;
          $display("FAIL done_match: cycle %0d data %h, required cycle %0d data %h",
                   cyc, b2.mem_ctrl_data, mon_e.cyc, mon_e.data);
        end
      end
    end
  end

  task automatic drive(input memory_op_t op, input logic [AddrW-1:0] addr,
                       input logic [DataW-1:0] data);
    b2.lsq_req_valid   = 1'b1;
    b2.lsq_req_op      = op;
    b2.lsq_req_address = addr;
    b2.lsq_req_data    = data;
    @(negedge clk);
    b2.lsq_req_valid   = 1'b0;
    b2.lsq_req_op      = no_mem_op;
    b2.lsq_req_address = '0;
    b2.lsq_req_data    = '0;
  endtask

  // Returns at the negedge of the cycle after the done pulse
  task automatic wait_done(input string name);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done_cnt == start) begin
      fails++;
      $display("FAIL %s_timeout: no done within 20 cycles, required one done", name);
    end
  endtask

  task automatic test_reset();
    int en0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (b2.mem_ctrl_ready !== 1'b1 || b2.mem_ctrl_done !== 1'b0 || b2.dmem_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ready %b done %b en %b, required 1 0 0",
               b2.mem_ctrl_ready, b2.mem_ctrl_done, b2.dmem_en);
    end
    tests++;
    if (b2.dmem_we !== 1'b0 || b2.dmem_addr !== '0 || b2.dmem_wdata !== '0
        || b2.mem_ctrl_data !== '0) begin
      fails++;
      $display("FAIL reset_bus: we %b addr %h wdata %h data %h, required all 0",
               b2.dmem_we, b2.dmem_addr, b2.dmem_wdata, b2.mem_ctrl_data);
    end
    tests++;
    if (b1.mem_ctrl_ready !== 1'b1 || b4.mem_ctrl_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_variants: ready1 %b ready4 %b, required 1 1",
               b1.mem_ctrl_ready, b4.mem_ctrl_ready);
    end
    reset = 1'b1;
    en0 = en_cnt;
    repeat (3) @(negedge clk);
    tests++;
    if (en_cnt !== en0 || b2.mem_ctrl_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle: en pulses %0d ready %b, required 0 1", en_cnt - en0,
               b2.mem_ctrl_ready);
    end
  endtask

  task automatic test_store_load();
    sb.push_back('{cyc + Lat + 2, '0});
    drive(mem_write, 'h10, 32'hDEAD_BEEF);
    tests++;
    if (b2.dmem_en !== 1'b1 || b2.dmem_we !== 1'b1 || b2.dmem_addr !== 'h10
        || b2.dmem_wdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL store_issue: en %b we %b addr %h wdata %h, required 1 1 010 deadbeef",
               b2.dmem_en, b2.dmem_we, b2.dmem_addr, b2.dmem_wdata);
    end
    tests++;
    if (b2.mem_ctrl_ready !== 1'b0) begin
      fails++;
      $display("FAIL store_busy: ready %b, required 0", b2.mem_ctrl_ready);
    end
    wait_done("store");
    tests++;
    if (b2.mem_ctrl_ready !== 1'b1) begin
      fails++;
      $display("FAIL store_ready_again: ready %b, required 1", b2.mem_ctrl_ready);
    end
    sb.push_back('{cyc + Lat + 2, 32'hDEAD_BEEF});
    drive(mem_read, 'h10, '0);
    tests++;
    if (b2.dmem_en !== 1'b1 || b2.dmem_we !== 1'b0 || b2.dmem_addr !== 'h10) begin
      fails++;
      $display("FAIL load_issue: en %b we %b addr %h, required 1 0 010",
               b2.dmem_en, b2.dmem_we, b2.dmem_addr);
    end
    @(negedge clk);
    tests++;
    if (b2.dmem_en !== 1'b0 || b2.dmem_addr !== '0 || b2.mem_ctrl_data !== '0) begin
      fails++;
      $display("FAIL wait_bus_zero: en %b addr %h data %h, required 0 0 0",
               b2.dmem_en, b2.dmem_addr, b2.mem_ctrl_data);
    end
    wait_done("load");
  endtask

  task automatic test_busy();
    int en0 = en_cnt;
    int d0 = done_cnt;
    sb.push_back('{cyc + Lat + 2, 32'hDEAD_BEEF});
    drive(mem_read, 'h10, '0);
    drive(mem_read, 'h20, '0);
    wait_done("busy");
    repeat (Lat + 4) @(negedge clk);
    tests++;
    if (en_cnt - en0 !== 1) begin
      fails++;
      $display("FAIL busy_en_pulses: %0d pulses, required 1", en_cnt - en0);
    end
    tests++;
    if (done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL busy_done_pulses: %0d pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_no_op();
    int en0 = en_cnt;
    b2.lsq_req_valid   = 1'b1;
    b2.lsq_req_op      = no_mem_op;
    b2.lsq_req_address = 'h30;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (b2.mem_ctrl_ready !== 1'b1 || b2.dmem_en !== 1'b0) begin
        fails++;
        $display("FAIL noop_idle: ready %b en %b, required 1 0", b2.mem_ctrl_ready,
                 b2.dmem_en);
      end
    end
    b2.lsq_req_valid   = 1'b0;
    b2.lsq_req_address = '0;
    @(negedge clk);
    tests++;
    if (en_cnt !== en0) begin
      fails++;
      $display("FAIL noop_en: %0d pulses, required 0", en_cnt - en0);
    end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    drive(mem_read, 'h10, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tests++;
    if (b2.mem_ctrl_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_ready: ready %b, required 1", b2.mem_ctrl_ready);
    end
    repeat (Lat + 4) @(negedge clk);
    tests++;
    if (done_cnt !== d0 || b2.mem_ctrl_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_done: %0d dones ready %b, required 0 1", done_cnt - d0,
               b2.mem_ctrl_ready);
    end
  endtask

  task automatic test_back_to_back();
    sb.push_back('{cyc + Lat + 2, '0});
    drive(mem_write, 'h44, 32'h1234_5678);
    wait_done("b2b_store");
    sb.push_back('{cyc + Lat + 2, 32'h1234_5678});
    drive(mem_read, 'h44, '0);
    wait_done("b2b_load0");
    sb.push_back('{cyc + Lat + 2, 32'hA500_0020});
    drive(mem_read, 'h20, '0);
    wait_done("b2b_load1");
  endtask

  task automatic test_latency();
    int unsigned t0 = cyc;
    int unsigned c1 = 0;
    int unsigned c4 = 0;
    logic [DataW-1:0] v1 = '0;
    logic [DataW-1:0] v4 = '0;
    b1.lsq_req_valid = 1'b1; b1.lsq_req_op = mem_read; b1.lsq_req_address = 'h5;
    b4.lsq_req_valid = 1'b1; b4.lsq_req_op = mem_read; b4.lsq_req_address = 'h6;
    @(negedge clk);
    b1.lsq_req_valid = 1'b0; b1.lsq_req_op = no_mem_op; b1.lsq_req_address = '0;
    b4.lsq_req_valid = 1'b0; b4.lsq_req_op = no_mem_op; b4.lsq_req_address = '0;
    for (int i = 0; i < 12; i++) begin
      if (b1.mem_ctrl_done === 1'b1 && c1 == 0) begin c1 = cyc; v1 = b1.mem_ctrl_data; end
      if (b4.mem_ctrl_done === 1'b1 && c4 == 0) begin c4 = cyc; v4 = b4.mem_ctrl_data; end
      @(negedge clk);
    end
    tests++;
    if (c1 - t0 !== 3 || v1 !== 32'hA500_0005) begin
      fails++;
      $display("FAIL lat1_read: latency %0d data %h, required 3 a5000005", c1 - t0, v1);
    end
    tests++;
    if (c4 - t0 !== 6 || v4 !== 32'hA500_0006) begin
      fails++;
      $display("FAIL lat4_read: latency %0d data %h, required 6 a5000006", c4 - t0, v4);
    end
  endtask

  initial begin
    b2.lsq_req_valid = 1'b0; b2.lsq_req_op = no_mem_op;
    b2.lsq_req_address = '0; b2.lsq_req_data = '0;
    b1.lsq_req_valid = 1'b0; b1.lsq_req_op = no_mem_op;
    b1.lsq_req_address = '0; b1.lsq_req_data = '0;
    b4.lsq_req_valid = 1'b0; b4.lsq_req_op = no_mem_op;
    b4.lsq_req_address = '0; b4.lsq_req_data = '0;
    test_reset();
    test_store_load();
    test_busy();
    test_no_op();
    test_reset_mid();
    test_back_to_back();
    test_latency();
    repeat (2) @(negedge clk);
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// Behavioural fixed-latency RAM: data for an en cycle appears MEM_LATENCY cycles later.
module d_mem_model import d_mem_ctrl_pkg::*; #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input logic       clk,
  d_mem_ctrl_if.ram bus
);

  logic [DataW-1:0] mem  [2**AddrW];
  logic [DataW-1:0] pipe [MEM_LATENCY];

  initial begin
    for (int i = 0; i < 2**AddrW; i++) mem[i] = DataW'(32'hA500_0000 | i);
    for (int i = 0; i < MEM_LATENCY; i++) pipe[i] = '0;
  end

  // Zeros fill the pipe on idle cycles so a mistimed capture is visible
  always @(posedge clk) begin
    pipe[0] <= bus.dmem_en ? mem[bus.dmem_addr] : '0;
    for (int i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
    if (bus.dmem_en && bus.dmem_we) mem[bus.dmem_addr] <= bus.dmem_wdata;
  end

  assign bus.dmem_rdata = pipe[MEM_LATENCY-1];

endmodule
